// File: rtl/mod_n_sequence_checker.sv
// Receive-side checker for a mod-MOD counter stream: locks onto 0,1,..,MOD-1,0,..
// after LOCK_CNT+1 consecutive correct samples, then flags errors and wraps with saturating stats.
module mod_n_sequence_checker #(
  parameter int MOD      = 7,
  parameter int WIDTH    = 3,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] count_in,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] wrap_count,
  output logic [WIDTH-1:0] expected
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);

  localparam logic [WIDTH:0]     MOD_V  = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0]   LAST_V = WIDTH'(MOD - 1);
  localparam logic [RUN_W-1:0]   LOCK_V = RUN_W'(LOCK_CNT);

  typedef enum logic [1:0] {UNLOCKED, SYNCING, LOCKED} state_t;

  state_t           state;
  logic [RUN_W-1:0] run;
  logic             legal;
  logic             match;
  logic             err_evt;
  logic             wrap_evt;
  logic [WIDTH-1:0] succ;

  // NOTE: every signal written in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    legal    = 1'b0;
    match    = 1'b0;
    err_evt  = 1'b0;
    wrap_evt = 1'b0;
    succ     = '0;
    legal    = {1'b0, count_in} < MOD_V;
    match    = legal && (count_in == expected);
    succ     = (count_in == LAST_V) ? '0 : count_in + WIDTH'(1);
    if (sample_en && state == LOCKED) begin
      err_evt  = !match;
      wrap_evt = match && (count_in == LAST_V);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= UNLOCKED;
      run        <= '0;
      expected   <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      err_pulse  <= err_evt;
      wrap_pulse <= wrap_evt;
      if (sample_en) begin
        case (state)
          UNLOCKED: begin
            if (legal) begin
              expected <= succ;
              run      <= '0;
              state    <= SYNCING;
            end
          end
          SYNCING: begin
            if (!legal) begin
              // Dropping out of sync forgets the reference, as after reset.
              expected <= '0;
              run      <= '0;
              state    <= UNLOCKED;
            end else if (match) begin
              expected <= succ;
              run      <= run + RUN_W'(1);
              if (run + RUN_W'(1) == LOCK_V) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              expected <= succ;
              run      <= '0;
            end
          end
          LOCKED: begin
            if (match) begin
              expected <= succ;
            end else begin
              expected <= '0;
              run      <= '0;
              locked   <= 1'b0;
              state    <= UNLOCKED;
            end
          end
          default: begin
            expected <= '0;
            run      <= '0;
            locked   <= 1'b0;
            state    <= UNLOCKED;
          end
        endcase
      end
    end
  end

  // Statistics saturate at all-ones; clr takes priority over a same-edge increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count  <= '0;
      wrap_count <= '0;
    end else if (clr) begin
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      if (err_evt && err_count != '1)
        err_count <= err_count + ERR_W'(1);
      if (wrap_evt && wrap_count != '1)
        wrap_count <= wrap_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_mod_n_sequence_checker.sv
// Bench for mod_n_sequence_checker: a history-based reference model checked every cycle,
// two DUT instances (8-bit and 2-bit statistics) sharing one directed stimulus stream.
module tb_mod_n_sequence_checker;

  localparam int MOD      = 7;
  localparam int WIDTH    = 3;
  localparam int LOCK_CNT = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             sample_en = 1'b0;
  logic [WIDTH-1:0] count_in = '0;
  logic             clr = 1'b0;

  logic             locked, err_pulse, wrap_pulse;
  logic [7:0]       err_count, wrap_count;
  logic [WIDTH-1:0] expected;

  logic             s_locked, s_err_pulse, s_wrap_pulse;
  logic [1:0]       s_err_count, s_wrap_count;
  logic [WIDTH-1:0] s_expected;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_n_sequence_checker #(.MOD(MOD), .WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .count_in(count_in), .clr(clr),
    .locked(locked), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse),
    .err_count(err_count), .wrap_count(wrap_count), .expected(expected)
  );

  mod_n_sequence_checker #(.MOD(MOD), .WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .sample_en(sample_en), .count_in(count_in), .clr(clr),
    .locked(s_locked), .err_pulse(s_err_pulse), .wrap_pulse(s_wrap_pulse),
    .err_count(s_err_count), .wrap_count(s_wrap_count), .expected(s_expected)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the checker is locked once it holds a reference value and has seen
  // at least LOCK_CNT correct successors of it; statistics are unbounded and clipped at compare.
  bit m_synced = 1'b0;
  int m_last   = 0;
  int m_streak = 0;
  int m_err    = 0;
  int m_wrap   = 0;
  bit m_errp   = 1'b0;
  bit m_wrapp  = 1'b0;

  function automatic int nxt(input int x);
    return (x == MOD - 1) ? 0 : x + 1;
  endfunction

  function automatic bit m_locked();
    return m_synced && (m_streak >= LOCK_CNT);
  endfunction

  function automatic int m_expected();
    return m_synced ? nxt(m_last) : 0;
  endfunction

  function automatic int clip(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  always @(negedge rst) begin
    m_synced = 1'b0; m_last = 0; m_streak = 0;
    m_err = 0; m_wrap = 0; m_errp = 1'b0; m_wrapp = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      int  v;
      bit  ok, was_locked;
      v          = int'(count_in);
      ok         = v < MOD;
      was_locked = m_locked();
      m_errp     = 1'b0;
      m_wrapp    = 1'b0;
      if (sample_en) begin
        if (was_locked) begin
          if (ok && v == nxt(m_last)) begin
            m_last = v;
            if (v == MOD - 1) m_wrapp = 1'b1;
          end else begin
            m_errp   = 1'b1;
            m_synced = 1'b0;
          end
        end else if (!ok) begin
          m_synced = 1'b0;
        end else if (m_synced && v == nxt(m_last)) begin
          m_last   = v;
          m_streak = m_streak + 1;
        end else begin
          m_synced = 1'b1;
          m_last   = v;
          m_streak = 0;
        end
      end
      if (clr) begin
        m_err  = 0;
        m_wrap = 0;
      end else begin
        m_err  = m_err + int'(m_errp);
        m_wrap = m_wrap + int'(m_wrapp);
      end
    end
  end

  always @(negedge clk) begin
    check("locked",       32'(locked),       32'(m_locked()));
    check("err_pulse",    32'(err_pulse),    32'(m_errp));
    check("wrap_pulse",   32'(wrap_pulse),   32'(m_wrapp));
    check("err_count",    32'(err_count),    32'(clip(m_err, 255)));
    check("wrap_count",   32'(wrap_count),   32'(clip(m_wrap, 255)));
    check("expected",     32'(expected),     32'(m_expected()));
    check("sat_locked",   32'(s_locked),     32'(m_locked()));
    check("sat_err_cnt",  32'(s_err_count),  32'(clip(m_err, 3)));
    check("sat_wrap_cnt", 32'(s_wrap_count), 32'(clip(m_wrap, 3)));
    check("sat_expected", 32'(s_expected),   32'(m_expected()));
    check("pulse_excl",   32'(err_pulse & wrap_pulse), 32'(0));
  end

  // Inputs change 1 time unit after an edge and are sampled at the following edge.
  task automatic step(input bit en, input int v, input bit c = 1'b0);
    sample_en = en;
    count_in  = WIDTH'(v);
    clr       = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_locked",   32'(locked),     32'(0));
    check("rst_expected", 32'(expected),   32'(0));
    check("rst_err_cnt",  32'(err_count),  32'(0));
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(1'b1, i % 7);
      if (i == 1) check("lock_not_yet", 32'(locked), 32'(0));
      if (i == 2) check("lock_at_3rd", 32'(locked), 32'(1));
      if (i == 6 || i == 13) check("wrap_at_6", 32'(wrap_pulse), 32'(1));
      if (i == 7) check("wrap_one_cycle", 32'(wrap_pulse), 32'(0));
    end
    check("wrap_cnt_20", 32'(wrap_count), 32'(2));
    check("err_cnt_20",  32'(err_count),  32'(0));
    check("exp_after_20", 32'(expected),  32'(6));

    // Skip from 3 to 5 while locked.
    step(1'b1, 6);
    for (int v = 0; v < 4; v++) step(1'b1, v);
    step(1'b1, 5);
    check("skip_err_pulse", 32'(err_pulse), 32'(1));
    check("skip_err_cnt",   32'(err_count), 32'(1));
    check("skip_unlocked",  32'(locked),    32'(0));
    step(1'b1, 6);
    check("resync_err_gone", 32'(err_pulse), 32'(0));
    check("resync_unlocked", 32'(locked),    32'(0));
    step(1'b1, 0);
    step(1'b1, 1);
    check("relock",          32'(locked),    32'(1));
    check("relock_err_cnt",  32'(err_count), 32'(1));

    // Illegal value while locked, then again while unlocked.
    step(1'b1, 2);
    step(1'b1, 3);
    check("exp_before_ill", 32'(expected), 32'(4));
    step(1'b1, 7);
    check("ill_err_pulse", 32'(err_pulse), 32'(1));
    check("ill_err_cnt",   32'(err_count), 32'(2));
    check("ill_unlocked",  32'(locked),    32'(0));
    step(1'b1, 7);
    check("ill2_ignored",  32'(err_count), 32'(2));
    check("ill2_no_pulse", 32'(err_pulse), 32'(0));

    // Sample-enable gaps with garbage on count_in.
    for (int v = 0; v < 3; v++) step(1'b1, v);
    step(1'b1, 3);
    step(1'b0, 7);
    check("gap_exp_hold1", 32'(expected), 32'(4));
    step(1'b0, 0);
    check("gap_exp_hold2", 32'(expected), 32'(4));
    check("gap_locked",    32'(locked),   32'(1));
    step(1'b1, 4);
    check("gap_no_err",    32'(err_count), 32'(2));
    check("gap_exp_next",  32'(expected),  32'(5));

    // Five lock/error cycles: the 2-bit counter saturates, the 8-bit one keeps counting.
    step(1'b1, 5);
    step(1'b1, 6);
    for (int k = 0; k < 5; k++) begin
      for (int v = 0; v < 3; v++) step(1'b1, v);
      step(1'b1, 5);
    end
    check("sat_err_3",   32'(s_err_count), 32'(3));
    check("wide_err_7",  32'(err_count),   32'(7));
    for (int v = 0; v < 3; v++) step(1'b1, v);
    step(1'b1, 5, 1'b1);
    check("clr_err_pulse", 32'(err_pulse),   32'(1));
    check("clr_err_cnt",   32'(err_count),   32'(0));
    check("clr_sat_cnt",   32'(s_err_count), 32'(0));
    check("clr_wrap_cnt",  32'(wrap_count),  32'(0));

    // Asynchronous reset between edges while locked with two wraps recorded.
    for (int i = 0; i < 14; i++) step(1'b1, i % 7);
    check("pre_rst_wraps",  32'(wrap_count), 32'(2));
    check("pre_rst_locked", 32'(locked),     32'(1));
    #3 rst = 1'b0;
    #1;
    check("async_locked",   32'(locked),     32'(0));
    check("async_wrap_cnt", 32'(wrap_count), 32'(0));
    check("async_expected", 32'(expected),   32'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    step(1'b1, 3);
    step(1'b1, 4);
    check("post_rst_sync", 32'(locked), 32'(0));
    step(1'b1, 5);
    check("post_rst_lock", 32'(locked),   32'(1));
    check("post_rst_exp",  32'(expected), 32'(6));
    step(1'b1, 6);
    check("post_rst_wrap", 32'(wrap_count), 32'(1));
    step(1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_n_sequence_checker.md
Name: mod_n_sequence_checker

Overview:
- Receive-side checker for a mod-N counter stream, such as the output of the team's mod-7 counter.
- Samples a count value on a qualifier strobe, locks to the sequence 0,1,...,MOD-1,0,... and flags every deviation.
- Keeps saturating error and wrap statistics.
- Used in-system as a self-check monitor and in benches as a synthesizable scoreboard.

Parameters:
- MOD, 7, modulus of the checked sequence (2..2**WIDTH).
- WIDTH, 3, width of the count input.
- LOCK_CNT, 2, consecutive correct successor samples required after the first sample before lock (>=1).
- ERR_W, 8, width of the statistics counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- sample_en  input  1  count_in is valid this cycle.
- count_in  input  WIDTH  observed counter value.
- clr  input  1  synchronous clear of err_count and wrap_count.
- locked  output  1  checker is locked to the sequence.
- err_pulse  output  1  one-cycle flag: sequence error detected while locked.
- wrap_pulse  output  1  one-cycle flag: MOD-1 observed while locked.
- err_count  output  ERR_W  saturating error count.
- wrap_count  output  ERR_W  saturating wrap count.
- expected  output  WIDTH  next value the checker expects.

Behaviour:
- Reset (rst=0, asynchronous, immediate, including mid-operation):
  - state=UNLOCKED.
  - All outputs 0; internal match-run counter 0.
- Successor function: next(x) = (x==MOD-1) ? 0 : x+1.
- Legal value: count_in < MOD; otherwise illegal.
- All outputs are registered. A sample taken at edge k is reflected in the outputs from edge k onward. Pulses are high for exactly one clock period.
- sample_en=0: state, expected and run counter hold; err_pulse=wrap_pulse=0.
- State machine, evaluated only when sample_en=1:
  - UNLOCKED:
    - Legal sample: expected<=next(count_in); run<=0; go to SYNCING.
    - Illegal sample: ignored, stay UNLOCKED.
    - No errors are counted in this state.
  - SYNCING:
    - count_in==expected: expected<=next(count_in); run<=run+1. If run+1==LOCK_CNT, go to LOCKED (locked=1).
    - Legal mismatch: resynchronise. expected<=next(count_in); run<=0; stay SYNCING.
    - Illegal sample: go to UNLOCKED.
    - No errors are counted in this state.
  - LOCKED:
    - count_in==expected: expected<=next(count_in). If count_in==MOD-1, assert wrap_pulse and increment wrap_count.
    - Mismatch or illegal sample: assert err_pulse, increment err_count, go to UNLOCKED, locked<=0, expected<=0.
- With LOCK_CNT=L, locked asserts at the edge of the (L+1)th consecutive correct sample.
- Statistics counters:
  - Saturate at all-ones and never wrap.
  - clr=1 forces both counters to 0 at the edge. clr wins over a simultaneous increment.
  - clr does not affect state, expected or the pulses.
- Only one of err_pulse / wrap_pulse can be high in any cycle.

Test Plan:
- Defaults; rst low 2 cycles then high; sample_en=1 every cycle; count_in=0,1,2,...,6,0,... for 20 samples.
  - locked=1 after the 3rd sample edge (value 2).
  - wrap_pulse at the samples of value 6 (samples 7 and 14).
  - wrap_count=2, err_count=0.
- Locked stream 0,1,2,3 then 5 (skip).
  - err_pulse high one cycle; err_count=1; locked=0.
  - Then 6,0,1: SYNCING after 6, locked=1 after sample 1; no further errors.
- Locked, expected=4, inject illegal value 7.
  - err_pulse=1; err_count increments; state UNLOCKED.
  - A second 7 is ignored (err_count unchanged).
- Locked stream with sample_en toggling 1,0,0,1; count_in driven with garbage while sample_en=0.
  - No errors; expected holds across gaps; locked stays 1.
- ERR_W=2: force 5 lock/error cycles.
  - err_count saturates at 3.
  - Assert clr on the same cycle as a 6th error: err_count=0, err_pulse=1.
- While locked with wrap_count=2, pull rst low between clock edges.
  - locked, counts and expected go to 0 immediately, before the next edge.
  - After release, a fresh stream must relock.
